// File: rtl/adc_frame_serializer.sv
// Snapshots NUM_CH parallel ADC samples on start and streams them LSB-first,
// channel 0 first, on s_data, qualified by the active-low data_valid.
//
// state | meaning
// IDLE  | waiting for start, data_valid high
// SHIFT | presenting one snapshot bit per cycle, data_valid low
// GAP   | data_valid held high GAP_CYCLES cycles before returning to IDLE
module adc_frame_serializer #(
    parameter int NUM_CH     = 32,
    parameter int BITS_ADC   = 12,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [NUM_CH*BITS_ADC-1:0] ch_data,
    output logic                       s_data,
    output logic                       data_valid,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                frame_cnt
);
    localparam int FRAME_BITS = NUM_CH * BITS_ADC;
    localparam int BIT_W      = (BITS_ADC > 1) ? $clog2(BITS_ADC) : 1;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_ADC - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                state_q, state_nxt;
    logic [FRAME_BITS-1:0] snap_q, snap_nxt;
    logic [BIT_W-1:0]      bit_q, bit_nxt;
    logic [CH_W-1:0]       ch_q, ch_nxt;
    logic [GAP_W-1:0]      gap_q, gap_nxt;
    logic [15:0]           frame_cnt_q, frame_cnt_nxt;
    logic                  s_data_q, s_data_nxt;
    logic                  dv_q, dv_nxt;
    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic [IDX_W-1:0]      idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            bit_q       <= '0;
            ch_q        <= '0;
            gap_q       <= '0;
            frame_cnt_q <= '0;
            s_data_q    <= 1'b0;
            dv_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            snap_q      <= snap_nxt;
            bit_q       <= bit_nxt;
            ch_q        <= ch_nxt;
            gap_q       <= gap_nxt;
            frame_cnt_q <= frame_cnt_nxt;
            s_data_q    <= s_data_nxt;
            dv_q        <= dv_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
        end
    end

    // bit_q/ch_q always name the bit currently on s_data.
    always_comb begin
        state_nxt     = state_q;
        snap_nxt      = snap_q;
        bit_nxt       = bit_q;
        ch_nxt        = ch_q;
        gap_nxt       = gap_q;
        frame_cnt_nxt = frame_cnt_q;
        s_data_nxt    = 1'b0;
        dv_nxt        = 1'b1;
        done_nxt      = 1'b0;
        idx           = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt  = SHIFT;
                    snap_nxt   = ch_data;
                    bit_nxt    = '0;
                    ch_nxt     = '0;
                    s_data_nxt = ch_data[0];
                    dv_nxt     = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_q == BIT_LAST && ch_q == CH_LAST) begin
                    state_nxt     = GAP;
                    done_nxt      = 1'b1;
                    frame_cnt_nxt = frame_cnt_q + 16'd1;
                    gap_nxt       = GAP_LOAD;
                    bit_nxt       = '0;
                    ch_nxt        = '0;
                end else begin
                    if (bit_q == BIT_LAST) begin
                        bit_nxt = '0;
                        ch_nxt  = ch_q + 1'b1;
                    end else begin
                        bit_nxt = bit_q + 1'b1;
                    end
                    idx        = IDX_W'(ch_nxt) * IDX_W'(BITS_ADC) + IDX_W'(bit_nxt);
                    s_data_nxt = snap_q[idx];
                    dv_nxt     = 1'b0;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_q - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign s_data     = s_data_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Bench for adc_frame_serializer: random frames checked against a queue-based
// model of the downstream deserializer plus framing/timing checks.
module tb_adc_frame_serializer;
    localparam int NUM_CH     = 32;
    localparam int BITS_ADC   = 12;
    localparam int GAP_CYCLES = 2;
    localparam int FRAME_BITS = NUM_CH * BITS_ADC;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [FRAME_BITS-1:0] ch_data = '0;
    logic                  s_data;
    logic                  data_valid;
    logic                  busy;
    logic                  done;
    logic [15:0]           frame_cnt;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_frames = '0;

    adc_frame_serializer #(
        .NUM_CH    (NUM_CH),
        .BITS_ADC  (BITS_ADC),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ch_data   (ch_data),
        .s_data    (s_data),
        .data_valid(data_valid),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FRAME_BITS-1:0] rand_frame();
        logic [FRAME_BITS-1:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*BITS_ADC +: BITS_ADC] = BITS_ADC'($urandom_range(0, 4095));
        return d;
    endfunction

    // Called at a negedge with the DUT idle. Collects the serial stream into a
    // bit queue and rebuilds channel words the way the deserializer would.
    task automatic send_frame(input logic [FRAME_BITS-1:0] d, input string tag,
                              input bit mutate, input bit poke_start);
        bit                  bitq[$];
        int                  low_cnt = 0;
        int                  done_cnt = 0;
        logic [BITS_ADC-1:0] w;
        ch_data = d;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "/busy_first"}, busy, 1);
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (data_valid === 1'b0) begin
                low_cnt++;
                bitq.push_back(s_data);
            end
            if (done) done_cnt++;
            if (mutate && k == 4) ch_data = {NUM_CH{12'hFFF}};
            start = poke_start && (k == 9 || k == FRAME_BITS - 1);
            @(negedge clk);
        end
        start = 1'b0;
        exp_frames++;
        check_eq({tag, "/low_cycles"}, low_cnt, FRAME_BITS);
        check_eq({tag, "/early_done"}, done_cnt, 0);
        check_eq({tag, "/dv_end"}, data_valid, 1);
        check_eq({tag, "/sdata_end"}, s_data, 0);
        check_eq({tag, "/done"}, done, 1);
        check_eq({tag, "/frame_cnt"}, frame_cnt, exp_frames);
        for (int c = 0; c < NUM_CH; c++) begin
            w = '0;
            for (int b = 0; b < BITS_ADC; b++)
                if (bitq.size() > 0) w[b] = bitq.pop_front();
            check_eq($sformatf("%s/ch%0d", tag, c), w, d[c*BITS_ADC +: BITS_ADC]);
        end
        for (int g = 1; g <= GAP_CYCLES; g++) begin
            @(negedge clk);
            check_eq($sformatf("%s/gap%0d_busy", tag, g), busy, (g < GAP_CYCLES) ? 1 : 0);
            check_eq($sformatf("%s/gap%0d_dv", tag, g), data_valid, 1);
            check_eq($sformatf("%s/gap%0d_done", tag, g), done, 0);
        end
        if (poke_start) begin
            repeat (2) @(negedge clk);
            check_eq({tag, "/no_restart_dv"}, data_valid, 1);
            check_eq({tag, "/no_restart_busy"}, busy, 0);
            check_eq({tag, "/no_restart_cnt"}, frame_cnt, exp_frames);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FRAME_BITS-1:0] d;
        int low_runs[$];
        int high_runs[$];
        int run_len;
        logic cur;

        repeat (2) @(negedge clk);
        check_eq("rst/dv", data_valid, 1);
        check_eq("rst/sdata", s_data, 0);
        check_eq("rst/busy", busy, 0);
        check_eq("rst/done", done, 0);
        check_eq("rst/frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NUM_CH; i++) d[i*BITS_ADC +: BITS_ADC] = 12'h100 + BITS_ADC'(i);
        send_frame(d, "single", 1'b0, 1'b0);

        // Abort a frame with an asynchronous reset between clock edges.
        ch_data = rand_frame();
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("midrst/dv_before", data_valid, 0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst/dv", data_valid, 1);
        check_eq("midrst/sdata", s_data, 0);
        check_eq("midrst/busy", busy, 0);
        check_eq("midrst/done", done, 0);
        check_eq("midrst/frame_cnt", frame_cnt, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        exp_frames = '0;
        @(negedge clk);
        check_eq("midrst/no_done", done, 0);
        send_frame(rand_frame(), "after_rst", 1'b0, 1'b0);

        for (int f = 0; f < 3; f++) send_frame(rand_frame(), $sformatf("loop%0d", f), 1'b0, 1'b0);

        send_frame(rand_frame(), "snapshot", 1'b1, 1'b0);
        send_frame(rand_frame(), "busy_start", 1'b0, 1'b1);

        // Continuous start: measure data_valid run lengths over three frames.
        ch_data = rand_frame();
        start   = 1'b1;
        cur     = 1'b1;
        run_len = 0;
        for (int c = 0; c < 4 * (FRAME_BITS + GAP_CYCLES + 1) && low_runs.size() < 3; c++) begin
            @(negedge clk);
            if (data_valid !== cur) begin
                if (cur == 1'b0) low_runs.push_back(run_len);
                else if (low_runs.size() > 0) high_runs.push_back(run_len);
                cur     = data_valid;
                run_len = 0;
            end
            run_len++;
        end
        start = 1'b0;
        exp_frames += 16'd3;
        check_eq("held/frames_seen", low_runs.size(), 3);
        foreach (low_runs[i]) check_eq($sformatf("held/low%0d", i), low_runs[i], FRAME_BITS);
        check_eq("held/gaps_seen", high_runs.size(), 2);
        foreach (high_runs[i]) check_eq($sformatf("held/high%0d", i), high_runs[i], GAP_CYCLES + 1);
        repeat (GAP_CYCLES + 2) @(negedge clk);
        check_eq("held/busy_after", busy, 0);
        check_eq("held/frame_cnt", frame_cnt, exp_frames);

        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        check_eq("wrap/preload", frame_cnt, 16'hFFFF);
        exp_frames = 16'hFFFF;
        send_frame(rand_frame(), "wrap", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
